rom_loader_receiver: RTL and testbench
======================================

Name: rom_loader_receiver

Overview:
SoC-side responder for the ROM loading interface. It accepts instruction words pushed by an external loader over the rom_loader_reset/load/data lines and answers with load_received and ack. Each accepted word is written to consecutive ROM addresses through a single-outstanding write request to the ROM QSPI SRAM controller. It sits inside hack_soc, between the ROM loading pins and the ROM controller write port.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDRESS_WIDTH, 16, ROM word address width; the address counter wraps modulo 2^ADDRESS_WIDTH

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
rom_loader_reset  input  1  loader session start; clears the address counter
rom_loader_load  input  1  loader asserts while rom_loader_data is valid
rom_loader_data  input  DATA_WIDTH  word to store
rom_loader_ack  output  1  word committed to ROM; held until load drops
rom_loader_load_received  output  1  one-cycle pulse when the word is captured
mem_req  output  1  write request to the ROM controller
mem_addr  output  ADDRESS_WIDTH  write address; stable while mem_req is high
mem_data  output  DATA_WIDTH  write data; stable while mem_req is high
mem_done  input  1  one-cycle pulse from the controller: write finished
busy  output  1  high in any state except IDLE
words_loaded  output  ADDRESS_WIDTH+1  words committed since the last session start; saturating
wrapped  output  1  sticky; set when the address counter wraps past 2^ADDRESS_WIDTH-1

Behaviour:
- Reset: state IDLE; all outputs 0; address counter 0; pending-reset flag 0.
- States:
  - IDLE: mem_req=0, ack=0.
    - load=1 and rom_loader_reset=0 -> CAPTURE.
  - CAPTURE (1 cycle): latch data into mem_data; mem_addr = address counter; pulse load_received=1 -> WRITE.
  - WRITE: mem_req=1, mem_addr and mem_data held.
    - mem_done -> address counter +1, words_loaded +1 (saturates at 2^ADDRESS_WIDTH), mem_req=0 next cycle -> ACK.
    - Address counter step from 2^ADDRESS_WIDTH-1 wraps to 0 and sets wrapped.
  - ACK: rom_loader_ack=1.
    - Stay while load=1; when load=0, ack=0 next cycle -> IDLE.
- Latency: load rising in IDLE (cycle 0) -> load_received at cycle 1 -> mem_req from cycle 2 -> ack in the cycle after mem_done.
- Ack stays high until load is sampled low. A word is never stored twice for one load assertion.
- Data is sampled only in CAPTURE. Changes on rom_loader_data afterwards are ignored.
- mem_done outside WRITE is ignored.
- rom_loader_reset (session start), sampled high:
  - In IDLE/CAPTURE/ACK: next cycle address=0, words_loaded=0, wrapped=0, ack=0, state IDLE. A word in CAPTURE is discarded (no mem_req issued).
  - In WRITE: set pending flag; mem_req stays high until mem_done (an SPI transaction is never aborted). On mem_done, skip ACK, apply the clear and go IDLE. No ack is given for that word.
  - While rom_loader_reset=1, load is ignored and the block stays IDLE.
- Load and rom_loader_reset both high in IDLE: the reset wins; no capture.
- System reset mid-transaction aborts immediately (mem_req=0). The controller is reset by the same signal.
- busy=1 in CAPTURE, WRITE and ACK, and while the pending flag is set.

Test Plan:
- Single word: rom_loader_reset 1 cycle, then load with data 16'hEC10 and mem_done 3 cycles after mem_req rises -> load_received pulse at cycle 1; mem_addr=0, mem_data=16'hEC10; ack high until load drops; words_loaded=1.
- Stream: 5 words 16'h0001..16'h0005 with random mem_done delays (1-20 cycles) and random load-low gaps -> writes to addresses 0..4 in order, each exactly once; words_loaded=5.
- Ack hold: keep load high 10 cycles after ack -> ack stays 1, no second mem_req; drop load -> ack 0 next cycle.
- Mid-write session reset: rom_loader_reset during WRITE at address 3 -> mem_req held until mem_done, no ack; next word goes to address 0; words_loaded=1 after it.
- Wrap: ADDRESS_WIDTH=4, load 17 words -> 17th word at address 0; wrapped=1; words_loaded=16 (saturated).
- System reset in WRITE -> next cycle mem_req=0, ack=0, load_received=0, busy=0, words_loaded=0.

Source files
------------

// File: rtl/rom_loader_receiver.sv
// Receives instruction words from the external ROM loader and writes each one to the
// next ROM address through a single-outstanding request to the ROM controller.
module rom_loader_receiver #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rom_loader_reset,
    input  logic                     rom_loader_load,
    input  logic [DATA_WIDTH-1:0]    rom_loader_data,
    output logic                     rom_loader_ack,
    output logic                     rom_loader_load_received,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     mem_done,
    output logic                     busy,
    output logic [ADDRESS_WIDTH:0]   words_loaded,
    output logic                     wrapped
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX  = {ADDRESS_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH:0]   WORDS_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   WORDS_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [1:0]               r_state;
    logic                     r_pending;
    logic                     r_ack;
    logic                     r_load_received;
    logic                     r_mem_req;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_data;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH:0]   r_words;
    logic                     r_wrapped;

    logic w_write_end;
    logic w_session_clear;
    logic w_commit;

    // A write that finishes while a session start is pending (or arriving) is not committed.
    assign w_write_end     = (r_state == S_WRITE) && mem_done;
    assign w_session_clear = (rom_loader_reset && (r_state != S_WRITE)) ||
                             (w_write_end && (r_pending || rom_loader_reset));
    assign w_commit        = w_write_end && !r_pending && !rom_loader_reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pending       <= 1'b0;
            r_ack           <= 1'b0;
            r_load_received <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack     <= 1'b0;
                    r_mem_req <= 1'b0;
                    if (!rom_loader_reset && rom_loader_load) begin
                        r_state         <= S_CAPTURE;
                        r_load_received <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_load_received <= 1'b0;
                    if (rom_loader_reset) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mem_data <= rom_loader_data;
                        r_mem_addr <= r_addr;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (rom_loader_reset) begin
                        r_pending <= 1'b1;
                    end
                    if (mem_done) begin
                        r_mem_req <= 1'b0;
                        if (r_pending || rom_loader_reset) begin
                            r_pending <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (rom_loader_reset || !rom_loader_load) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_session_clear) begin
            r_addr    <= '0;
            r_words   <= '0;
            r_wrapped <= 1'b0;
        end else if (w_commit) begin
            r_addr <= r_addr + ADDR_ONE;
            if (r_addr == ADDR_MAX) begin
                r_wrapped <= 1'b1;
            end
            if (r_words != WORDS_MAX) begin
                r_words <= r_words + WORDS_ONE;
            end
        end
    end

    assign rom_loader_ack           = r_ack;
    assign rom_loader_load_received = r_load_received;
    assign mem_req                  = r_mem_req;
    assign mem_addr                 = r_mem_addr;
    assign mem_data                 = r_mem_data;
    assign busy                     = (r_state != S_IDLE) || r_pending;
    assign words_loaded             = r_words;
    assign wrapped                  = r_wrapped;

endmodule

// File: tb/tb_rom_loader_receiver.sv
// Directed bench for rom_loader_receiver with a 4-bit address space so the wrap is reachable.
module tb_rom_loader_receiver;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rom_loader_reset = 1'b0;
    logic          rom_loader_load = 1'b0;
    logic [DW-1:0] rom_loader_data = '0;
    logic          rom_loader_ack;
    logic          rom_loader_load_received;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_done = 1'b0;
    logic          busy;
    logic [AW:0]   words_loaded;
    logic          wrapped;

    int n_tests = 0;
    int n_fail  = 0;

    rom_loader_receiver #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .rom_loader_reset         (rom_loader_reset),
        .rom_loader_load          (rom_loader_load),
        .rom_loader_data          (rom_loader_data),
        .rom_loader_ack           (rom_loader_ack),
        .rom_loader_load_received (rom_loader_load_received),
        .mem_req                  (mem_req),
        .mem_addr                 (mem_addr),
        .mem_data                 (mem_data),
        .mem_done                 (mem_done),
        .busy                     (busy),
        .words_loaded             (words_loaded),
        .wrapped                  (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic session_start();
        rom_loader_reset = 1'b1;
        step();
        rom_loader_reset = 1'b0;
        step();
    endtask

    // One complete loader handshake: capture, write with dly cycles before mem_done, ack hold.
    task automatic write_word(input logic [DW-1:0] d, input int dly, input int hold,
                              input logic [AW-1:0] exp_addr);
        rom_loader_load = 1'b1;
        rom_loader_data = d;
        step();
        check("capture_lr", {31'd0, rom_loader_load_received}, 32'd1);
        check("capture_req", {31'd0, mem_req}, 32'd0);
        check("capture_busy", {31'd0, busy}, 32'd1);
        step();
        rom_loader_data = ~d;
        check("write_req", {31'd0, mem_req}, 32'd1);
        check("write_lr", {31'd0, rom_loader_load_received}, 32'd0);
        check("write_addr", {28'd0, mem_addr}, {28'd0, exp_addr});
        check("write_data", {16'd0, mem_data}, {16'd0, d});
        repeat (dly) begin
            step();
            check("write_hold_req", {31'd0, mem_req}, 32'd1);
        end
        check("write_hold_data", {16'd0, mem_data}, {16'd0, d});
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("ack_set", {31'd0, rom_loader_ack}, 32'd1);
        check("ack_req_low", {31'd0, mem_req}, 32'd0);
        repeat (hold) begin
            step();
            check("ack_hold", {31'd0, rom_loader_ack}, 32'd1);
            check("ack_no_rewrite", {31'd0, mem_req}, 32'd0);
        end
        rom_loader_load = 1'b0;
        step();
        check("ack_drop", {31'd0, rom_loader_ack}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    int stream_dly [5] = '{1, 7, 20, 3, 12};
    int stream_gap [5] = '{0, 2, 5, 1, 3};

    initial begin
        step();
        step();
        check("rst_ack", {31'd0, rom_loader_ack}, 32'd0);
        check("rst_lr", {31'd0, rom_loader_load_received}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_data", {16'd0, mem_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_words", {27'd0, words_loaded}, 32'd0);
        check("rst_wrapped", {31'd0, wrapped}, 32'd0);
        reset = 1'b0;
        step();

        session_start();
        write_word(16'hEC10, 3, 0, 4'd0);
        check("single_words", {27'd0, words_loaded}, 32'd1);

        write_word(16'h1234, 2, 10, 4'd1);
        check("hold_words", {27'd0, words_loaded}, 32'd2);

        session_start();
        check("session_words", {27'd0, words_loaded}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            repeat (stream_gap[i]) step();
            write_word(16'(i + 1), stream_dly[i], i, 4'(i));
        end
        check("stream_words", {27'd0, words_loaded}, 32'd5);

        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        step();
        check("stray_done_words", {27'd0, words_loaded}, 32'd5);
        check("stray_done_ack", {31'd0, rom_loader_ack}, 32'd0);

        session_start();
        for (int i = 0; i < 3; i++) write_word(16'h00A0 + 16'(i), 1, 0, 4'(i));
        rom_loader_load = 1'b1;
        rom_loader_data = 16'hBEEF;
        step();
        step();
        check("midrst_addr", {28'd0, mem_addr}, 32'd3);
        rom_loader_reset = 1'b1;
        rom_loader_load  = 1'b0;
        step();
        rom_loader_reset = 1'b0;
        check("midrst_req_held", {31'd0, mem_req}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        step();
        check("midrst_req_held2", {31'd0, mem_req}, 32'd1);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("midrst_no_ack", {31'd0, rom_loader_ack}, 32'd0);
        check("midrst_req_low", {31'd0, mem_req}, 32'd0);
        check("midrst_busy_low", {31'd0, busy}, 32'd0);
        check("midrst_words", {27'd0, words_loaded}, 32'd0);
        step();
        write_word(16'hABCD, 2, 0, 4'd0);
        check("midrst_next_words", {27'd0, words_loaded}, 32'd1);

        session_start();
        for (int i = 0; i < 17; i++) begin
            write_word(16'h0100 + 16'(i), 1, 0, 4'(i));
            if (i == 14) begin
                check("wrap_not_yet", {31'd0, wrapped}, 32'd0);
                check("wrap_words15", {27'd0, words_loaded}, 32'd15);
            end
            if (i == 15) begin
                check("wrap_set", {31'd0, wrapped}, 32'd1);
                check("wrap_words16", {27'd0, words_loaded}, 32'd16);
            end
        end
        check("wrap_sticky", {31'd0, wrapped}, 32'd1);
        check("wrap_saturated", {27'd0, words_loaded}, 32'd16);

        rom_loader_load  = 1'b1;
        rom_loader_reset = 1'b1;
        step();
        rom_loader_load  = 1'b0;
        rom_loader_reset = 1'b0;
        check("both_high_lr", {31'd0, rom_loader_load_received}, 32'd0);
        check("both_high_busy", {31'd0, busy}, 32'd0);
        check("both_high_words", {27'd0, words_loaded}, 32'd0);
        check("both_high_wrapped", {31'd0, wrapped}, 32'd0);
        step();
        check("both_high_idle", {31'd0, busy}, 32'd0);

        write_word(16'h5555, 1, 0, 4'd0);
        rom_loader_load = 1'b1;
        rom_loader_data = 16'h7777;
        step();
        rom_loader_reset = 1'b1;
        rom_loader_load  = 1'b0;
        step();
        rom_loader_reset = 1'b0;
        check("capture_discard_req", {31'd0, mem_req}, 32'd0);
        check("capture_discard_busy", {31'd0, busy}, 32'd0);
        check("capture_discard_words", {27'd0, words_loaded}, 32'd0);
        step();
        check("capture_discard_req2", {31'd0, mem_req}, 32'd0);

        write_word(16'h4321, 1, 0, 4'd0);
        rom_loader_load = 1'b1;
        rom_loader_data = 16'h9999;
        step();
        step();
        check("sysrst_pre_req", {31'd0, mem_req}, 32'd1);
        check("sysrst_pre_words", {27'd0, words_loaded}, 32'd1);
        reset = 1'b1;
        rom_loader_load = 1'b0;
        step();
        check("sysrst_req", {31'd0, mem_req}, 32'd0);
        check("sysrst_ack", {31'd0, rom_loader_ack}, 32'd0);
        check("sysrst_lr", {31'd0, rom_loader_load_received}, 32'd0);
        check("sysrst_busy", {31'd0, busy}, 32'd0);
        check("sysrst_words", {27'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
